// File: rtl/uart_fifo_core_if.sv
// Register-file side of uart_fifo_core: FIFO strobes, data, levels and sticky error flags.
// master = bus register file, slave = UART core.
interface uart_fifo_core_if #(
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
);
  logic [DATA_BITS-1:0]          tx_data;
  logic                          tx_wr;
  logic                          tx_full;
  logic [$clog2(TX_DEPTH+1)-1:0] tx_level;
  logic                          tx_busy;
  logic [DATA_BITS-1:0]          rx_data;
  logic                          rx_rd;
  logic                          rx_empty;
  logic [$clog2(RX_DEPTH+1)-1:0] rx_level;
  logic                          err_clr;
  logic                          rx_overrun;
  logic                          frame_err;
  logic                          parity_err;

  modport master (
    output tx_data, tx_wr, rx_rd, err_clr,
    input  tx_full, tx_level, tx_busy, rx_data, rx_empty, rx_level,
           rx_overrun, frame_err, parity_err
  );

  modport slave (
    input  tx_data, tx_wr, rx_rd, err_clr,
    output tx_full, tx_level, tx_busy, rx_data, rx_empty, rx_level,
           rx_overrun, frame_err, parity_err
  );
endinterface

// File: rtl/uart_fifo_core.sv
// UART with fractional baud generator, TX/RX FIFOs and sticky error flags.
// Optional parity bit on both directions when UART_PARITY_EN is defined.
module uart_fifo_core #(
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ser_in,
  output logic            ser_out,
  input  logic [11:0]     baud_freq,
  input  logic [15:0]     baud_limit,
  input  logic            stop2,
  input  logic            parity_odd,
  uart_fifo_core_if.slave bus
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int TXL = $clog2(TX_DEPTH + 1);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXL = $clog2(RX_DEPTH + 1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] MID_TICK = 4'd7;
  localparam logic [3:0] END_TICK = 4'd15;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP1, TX_STOP2
  } tx_state_t;

`ifdef UART_PARITY_EN
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // Baud generator: fractional accumulator, ce_q pulses at 16x bit rate
  logic [15:0] acc_q, acc_d;
  logic [16:0] acc_sum;
  logic        ce_q, ce_d;

  always_comb begin
    acc_sum = {1'b0, acc_q} + {5'd0, baud_freq};
    acc_d   = acc_sum[15:0];
    ce_d    = 1'b0;
    if (acc_sum >= {1'b0, baud_limit}) begin
      acc_d = 16'(acc_sum - {1'b0, baud_limit});
      ce_d  = 1'b1;
    end
  end

  logic [1:0] sync_q, sync_d;
  logic       rx_prev_q, rx_prev_d, rx_bit;
  assign sync_d    = {sync_q[0], ser_in};
  assign rx_bit    = sync_q[1];
  assign rx_prev_d = rx_bit;

  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
  logic [RXA-1:0]       rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXL-1:0]       rx_level_q, rx_level_d;
  logic                 rx_full, rx_empty, rx_push, rx_pop;

  // RX framer
  rx_state_t            rx_state_q, rx_state_d;
  logic [3:0]           rx_tick_q, rx_tick_d, rx_cnt_q, rx_cnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_push_q, rx_push_d, frame_set;
  logic                 overrun_q, overrun_d, frame_q, frame_d;
`ifdef UART_PARITY_EN
  logic                 parity_set, parity_q, parity_d;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_push_d  = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_PARITY_EN
    parity_set = 1'b0;
`endif
    case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !rx_bit) begin
        rx_state_d = RX_START;
        rx_tick_d  = '0;
      end
      RX_START: if (ce_q) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == MID_TICK && rx_bit) begin
          rx_state_d = RX_IDLE;
        end else if (rx_tick_q == END_TICK) begin
          rx_state_d = RX_DATA;
          rx_tick_d  = '0;
          rx_cnt_d   = '0;
        end
      end
      RX_DATA: if (ce_q) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == MID_TICK) rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
        if (rx_tick_q == END_TICK) begin
          rx_tick_d = '0;
          rx_cnt_d  = rx_cnt_q + 4'd1;
`ifdef UART_PARITY_EN
          if (rx_cnt_q == LAST_BIT) rx_state_d = RX_PAR;
`else
          if (rx_cnt_q == LAST_BIT) rx_state_d = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PAR: if (ce_q) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == MID_TICK && rx_bit != parity_of(rx_shift_q, parity_odd)) parity_set = 1'b1;
        if (rx_tick_q == END_TICK) begin
          rx_state_d = RX_STOP;
          rx_tick_d  = '0;
        end
      end
`endif
      // Leave STOP right after the sample so the next start edge is never missed
      RX_STOP: if (ce_q) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == MID_TICK) begin
          frame_set  = !rx_bit;
          rx_push_d  = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign rx_full  = (rx_level_q == RXL'(RX_DEPTH));
  assign rx_empty = (rx_level_q == '0);
  assign rx_push  = rx_push_q && !rx_full;
  assign rx_pop   = bus.rx_rd && !rx_empty;

  always_comb begin
    rx_wptr_d  = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
    rx_rptr_d  = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
    rx_level_d = rx_level_q;
    if (rx_push && !rx_pop)      rx_level_d = rx_level_q + 1'b1;
    else if (!rx_push && rx_pop) rx_level_d = rx_level_q - 1'b1;
    overrun_d = (overrun_q & ~bus.err_clr) | (rx_push_q & rx_full);
    frame_d   = (frame_q & ~bus.err_clr) | frame_set;
`ifdef UART_PARITY_EN
    parity_d  = (parity_q & ~bus.err_clr) | parity_set;
`endif
  end

  // TX FIFO and serialiser
  logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
  logic [TXA-1:0]       tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TXL-1:0]       tx_level_q, tx_level_d;
  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_load;
  logic [DATA_BITS-1:0] tx_head;
  tx_state_t            tx_state_q, tx_state_d;
  logic [3:0]           tx_tick_q, tx_tick_d, tx_cnt_q, tx_cnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_stop2_q, tx_stop2_d;
`ifdef UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  assign tx_full  = (tx_level_q == TXL'(TX_DEPTH));
  assign tx_empty = (tx_level_q == '0);
  assign tx_push  = bus.tx_wr && !tx_full;
  assign tx_head  = tx_mem_q[tx_rptr_q];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_stop2_d = tx_stop2_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    if (tx_state_q != TX_IDLE && ce_q) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_IDLE:  if (ce_q) tx_load = 1'b1;
      TX_START: if (ce_q && tx_tick_q == END_TICK) begin
        tx_state_d = TX_DATA;
        tx_tick_d  = '0;
        tx_cnt_d   = '0;
      end
      TX_DATA: if (ce_q && tx_tick_q == END_TICK) begin
        tx_tick_d  = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_cnt_d   = tx_cnt_q + 4'd1;
`ifdef UART_PARITY_EN
        if (tx_cnt_q == LAST_BIT) tx_state_d = TX_PAR;
`else
        if (tx_cnt_q == LAST_BIT) tx_state_d = TX_STOP1;
`endif
      end
`ifdef UART_PARITY_EN
      TX_PAR: if (ce_q && tx_tick_q == END_TICK) begin
        tx_state_d = TX_STOP1;
        tx_tick_d  = '0;
      end
`endif
      TX_STOP1: if (ce_q && tx_tick_q == END_TICK) begin
        if (tx_stop2_q) begin
          tx_state_d = TX_STOP2;
          tx_tick_d  = '0;
        end else begin
          tx_load = 1'b1;
        end
      end
      TX_STOP2: if (ce_q && tx_tick_q == END_TICK) tx_load = 1'b1;
      default:  tx_state_d = TX_IDLE;
    endcase
    // End of a frame chains straight into the next start bit when data is waiting
    if (tx_load) begin
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_tick_d  = '0;
        tx_shift_d = tx_head;
        tx_stop2_d = stop2;
`ifdef UART_PARITY_EN
        tx_par_d   = parity_of(tx_head, parity_odd);
`endif
      end else begin
        tx_state_d = TX_IDLE;
      end
    end
  end

  always_comb begin
    tx_wptr_d  = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
    tx_rptr_d  = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
    tx_level_d = tx_level_q;
    if (tx_push && !tx_pop)      tx_level_d = tx_level_q + 1'b1;
    else if (!tx_push && tx_pop) tx_level_d = tx_level_q - 1'b1;
  end

  always_comb begin
    case (tx_state_q)
      TX_START: ser_out = 1'b0;
      TX_DATA:  ser_out = tx_shift_q[0];
`ifdef UART_PARITY_EN
      TX_PAR:   ser_out = tx_par_q;
`endif
      default:  ser_out = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      ce_q       <= 1'b0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_cnt_q   <= '0;
      rx_push_q  <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
      overrun_q  <= 1'b0;
      frame_q    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
      tx_par_q   <= 1'b0;
`endif
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_cnt_q   <= '0;
      tx_stop2_q <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
    end else begin
      acc_q      <= acc_d;
      ce_q       <= ce_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_push_q  <= rx_push_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
      overrun_q  <= overrun_d;
      frame_q    <= frame_d;
`ifdef UART_PARITY_EN
      parity_q   <= parity_d;
      tx_par_q   <= tx_par_d;
`endif
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_stop2_q <= tx_stop2_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
    end
  end

  always_ff @(posedge clock) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.tx_data;
  end

  assign bus.tx_full    = tx_full;
  assign bus.tx_level   = tx_level_q;
  assign bus.tx_busy    = (tx_state_q != TX_IDLE) || !tx_empty;
  assign bus.rx_data    = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
  assign bus.rx_empty   = rx_empty;
  assign bus.rx_level   = rx_level_q;
  assign bus.rx_overrun = overrun_q;
  assign bus.frame_err  = frame_q;
`ifdef UART_PARITY_EN
  assign bus.parity_err = parity_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
